// File: rtl/arith_decoder.sv
// Sequential 16-bit arithmetic decoder: FILL -> SEARCH -> OUT -> RENORM loop over a serial bitstream.
// Optional `ARITH_DEC_ERR_EN adds a sticky err output for illegal table writes and zero-width symbols.
module arith_decoder #(
  parameter  int SYMS = 16,
  localparam int SW   = $clog2(SYMS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cdf_wr_en,
  input  logic [SW-1:0] cdf_wr_addr,
  input  logic [15:0]   cdf_wr_data,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic          bit_ready,
  output logic [SW-1:0] sym_out,
  output logic          sym_valid,
  input  logic          sym_ready,
  output logic          busy
`ifdef ARITH_DEC_ERR_EN
  ,
  output logic          err
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_SEARCH = 3'd2;
  localparam logic [2:0] S_OUT    = 3'd3;
  localparam logic [2:0] S_RENORM = 3'd4;

  logic [2:0]    state;
  logic [15:0]   low, high, code;
  logic [SW-1:0] idx;
  logic [16:0]   prev_bound;
  logic [3:0]    fill_cnt;
  logic [15:0]   cdf_r [SYMS];

  logic [16:0]   range, cdf_hi;
  logic [33:0]   prod;
  logic [17:0]   bound;
  logic          hit, e12, e3;

  // Entries 0 and SYMS are the implicit 0 and 65536 end points of the table.
  function automatic logic [16:0] get_cdf(input logic [SW:0] k);
    if (k == '0) return '0;
    if (k == (SW+1)'(SYMS)) return 17'h10000;
    return {1'b0, cdf_r[k[SW-1:0]]};
  endfunction

  always_comb begin
    range     = {1'b0, high} - {1'b0, low} + 17'd1;
    cdf_hi    = get_cdf({1'b0, idx} + (SW+1)'(1));
    prod      = 34'(range) * 34'(cdf_hi);
    bound     = 18'(low) + 18'(prod >> 16);
    hit       = ({2'b00, code} < bound);
    e12       = (low[15] == high[15]);
    e3        = (low[15:14] == 2'b01) && (high[15:14] == 2'b10);
    bit_ready = (state == S_FILL) || ((state == S_RENORM) && (e12 || e3));
  end

  assign sym_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      low     <= 16'h0000;
      high    <= 16'hFFFF;
      code    <= 16'h0000;
      sym_out <= '0;
      for (int i = 0; i < SYMS; i++) cdf_r[i] <= 16'(i * 65536 / SYMS);
    end else begin
      if (cdf_wr_en && (state == S_IDLE) && (cdf_wr_addr != '0))
        cdf_r[cdf_wr_addr] <= cdf_wr_data;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_FILL;
            low      <= 16'h0000;
            high     <= 16'hFFFF;
            code     <= 16'h0000;
            fill_cnt <= 4'd0;
          end
        end
        S_FILL: begin
          if (bit_valid) begin
            code     <= {code[14:0], bit_in};
            fill_cnt <= fill_cnt + 4'd1;
            if (fill_cnt == 4'd15) begin
              state      <= S_SEARCH;
              idx        <= '0;
              prev_bound <= {1'b0, low};
            end
          end
        end
        // Linear search: the last symbol always hits because its bound is high+1.
        S_SEARCH: begin
          if (hit) begin
            sym_out <= idx;
            high    <= 16'(bound - 18'd1);
            low     <= prev_bound[15:0];
            state   <= S_OUT;
          end else begin
            prev_bound <= bound[16:0];
            idx        <= idx + SW'(1);
          end
        end
        S_OUT: begin
          if (sym_ready) state <= S_RENORM;
        end
        S_RENORM: begin
          if (e12 || e3) begin
            if (bit_valid) begin
              low  <= {low[14:0], 1'b0}     ^ {e3 && !e12, 15'd0};
              high <= {high[14:0], 1'b1}    ^ {e3 && !e12, 15'd0};
              code <= {code[14:0], bit_in}  ^ {e3 && !e12, 15'd0};
            end
          end else begin
            state      <= S_SEARCH;
            idx        <= '0;
            prev_bound <= {1'b0, low};
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ARITH_DEC_ERR_EN
  logic [16:0] nb_lo, nb_hi, cdf_lo;
  logic        wr_bad, zero_width;

  always_comb begin
    nb_lo      = get_cdf({1'b0, cdf_wr_addr} - (SW+1)'(1));
    nb_hi      = get_cdf({1'b0, cdf_wr_addr} + (SW+1)'(1));
    cdf_lo     = get_cdf({1'b0, idx});
    wr_bad     = cdf_wr_en && ((state != S_IDLE) ||
                 ((cdf_wr_addr != '0) &&
                  (({1'b0, cdf_wr_data} <= nb_lo) || ({1'b0, cdf_wr_data} >= nb_hi))));
    zero_width = (state == S_SEARCH) && hit && (cdf_lo == cdf_hi);
  end

  // Sticky: a new fault in the same cycle as a clearing start still wins.
  always_ff @(posedge clk) begin
    if (rst)                           err <= 1'b0;
    else if (wr_bad || zero_width)     err <= 1'b1;
    else if ((state == S_IDLE) && start) err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_arith_decoder.sv
// Directed bench for arith_decoder: vector table of single-symbol decodes, hand sequences
// for renormalisation, stalls and reset, and a round trip through a reference encoder.
module tb_arith_decoder;
  localparam int SYMS = 16;
  localparam int SW   = 4;
  localparam int NSYM = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          cdf_wr_en = 1'b0;
  logic [SW-1:0] cdf_wr_addr = '0;
  logic [15:0]   cdf_wr_data = '0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_ready;
  logic [SW-1:0] sym_out;
  logic          sym_valid;
  logic          sym_ready = 1'b0;
  logic          busy;
`ifdef ARITH_DEC_ERR_EN
  logic          err;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  arith_decoder #(.SYMS(SYMS)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cdf_wr_en(cdf_wr_en), .cdf_wr_addr(cdf_wr_addr), .cdf_wr_data(cdf_wr_data),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready), .busy(busy)
`ifdef ARITH_DEC_ERR_EN
    , .err(err)
`endif
  );

  typedef struct {
    logic        e3cfg;
    logic [15:0] code;
    logic [3:0]  sym;
    logic [15:0] lo;
    logic [15:0] hi;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic wr_cdf(input int a, input int d);
    cdf_wr_en   = 1'b1;
    cdf_wr_addr = SW'(a);
    cdf_wr_data = 16'(d);
    tick();
    cdf_wr_en = 1'b0;
  endtask

  // Descending order keeps every write monotonic against its current neighbours.
  task automatic cfg_e3();
    for (int i = 10; i >= 3; i--) wr_cdf(i, 'hA000 + (i - 2) * 'h100);
    wr_cdf(2, 'hA000);
    wr_cdf(1, 'h6000);
  endtask

  task automatic feed_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic start_fill(input logic [15:0] cw, input int stall_at);
    logic [15:0] snap;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (i == stall_at) begin
        snap = dut.code;
        repeat (5) tick();
        chk("fill_stall_code", dut.code, snap);
        chk("fill_stall_busy", busy, 1'b1);
      end
      feed_bit(cw[i]);
    end
  endtask

  task automatic wait_sym(output int n);
    n = 0;
    while (!sym_valid && n < 64) begin
      tick();
      n++;
    end
    if (!sym_valid) chk("sym_valid_timeout", 0, 1);
  endtask

  initial begin
    int          n;
    logic [15:0] s_lo, s_hi, s_cd;
    int          held_bad;

    vecs[0] = '{1'b0, 16'h0000, 4'd0,  16'h0000, 16'h0FFF};
    vecs[1] = '{1'b0, 16'hFFFF, 4'd15, 16'hF000, 16'hFFFF};
    vecs[2] = '{1'b0, 16'h3ABC, 4'd3,  16'h3000, 16'h3FFF};
    vecs[3] = '{1'b0, 16'h8000, 4'd8,  16'h8000, 16'h8FFF};
    vecs[4] = '{1'b0, 16'h7FFF, 4'd7,  16'h7000, 16'h7FFF};
    vecs[5] = '{1'b1, 16'h5FFF, 4'd0,  16'h0000, 16'h5FFF};
    vecs[6] = '{1'b1, 16'h6000, 4'd1,  16'h6000, 16'h9FFF};
    vecs[7] = '{1'b1, 16'hA000, 4'd2,  16'hA000, 16'hA0FF};

    // Reset values
    do_reset(2);
    chk("rst_sym_valid", sym_valid, 1'b0);
    chk("rst_sym_out", sym_out, 4'd0);
    chk("rst_bit_ready", bit_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cdf4", dut.cdf_r[4], 16'h4000);
    chk("rst_low", dut.low, 16'h0000);
    chk("rst_high", dut.high, 16'hFFFF);
    chk("rst_code", dut.code, 16'h0000);
`ifdef ARITH_DEC_ERR_EN
    chk("rst_err", err, 1'b0);
`endif

    // Table of single-symbol decodes
    for (int v = 0; v < 8; v++) begin
      do_reset(1);
      if (vecs[v].e3cfg) cfg_e3();
      start_fill(vecs[v].code, -1);
      wait_sym(n);
      chk($sformatf("vec%0d_latency", v), n, vecs[v].sym + 1);
      chk($sformatf("vec%0d_sym", v), sym_out, vecs[v].sym);
      chk($sformatf("vec%0d_low", v), dut.low, vecs[v].lo);
      chk($sformatf("vec%0d_high", v), dut.high, vecs[v].hi);
    end

    // Uniform decode with FILL, OUT and RENORM stalls
    do_reset(1);
    start_fill(16'h3ABC, 8);
    wait_sym(n);
    chk("uni_sym0", sym_out, 4'd3);
    chk("uni_sym0_lat", n, 4);
    held_bad = 0;
    repeat (7) begin
      tick();
      if (sym_out !== 4'd3 || sym_valid !== 1'b1) held_bad++;
    end
    chk("uni_hold_changes", held_bad, 0);
    sym_ready = 1'b1;
    tick();
    sym_ready = 1'b0;
    chk("uni_renorm_ready", bit_ready, 1'b1);
    feed_bit(1'b0);
    feed_bit(1'b1);
    s_lo = dut.low; s_hi = dut.high; s_cd = dut.code;
    repeat (5) tick();
    chk("renorm_stall_low", dut.low, s_lo);
    chk("renorm_stall_high", dut.high, s_hi);
    chk("renorm_stall_code", dut.code, s_cd);
    feed_bit(1'b0);
    feed_bit(1'b1);
    chk("uni_e1_low", dut.low, 16'h0000);
    chk("uni_e1_high", dut.high, 16'hFFFF);
    chk("uni_e1_code", dut.code, 16'hABC5);
    chk("uni_exit_ready", bit_ready, 1'b0);
    wait_sym(n);
    chk("uni_sym1", sym_out, 4'd10);
    chk("uni_sym1_lat", n, 12);

    // E3 path
    do_reset(1);
    cfg_e3();
    start_fill(16'h7000, -1);
    wait_sym(n);
    chk("e3_sym", sym_out, 4'd1);
    chk("e3_low0", dut.low, 16'h6000);
    chk("e3_high0", dut.high, 16'h9FFF);
    sym_ready = 1'b1;
    tick();
    sym_ready = 1'b0;
    chk("e3_ready", bit_ready, 1'b1);
    feed_bit(1'b0);
    chk("e3_low1", dut.low, 16'h4000);
    chk("e3_high1", dut.high, 16'hBFFF);
    chk("e3_code1", dut.code, 16'h6000);
    feed_bit(1'b0);
    chk("e3_low2", dut.low, 16'h0000);
    chk("e3_high2", dut.high, 16'hFFFF);
    chk("e3_code2", dut.code, 16'h4000);
    chk("e3_exit_ready", bit_ready, 1'b0);
    wait_sym(n);
    chk("e3_next_sym", sym_out, 4'd0);
    chk("e3_next_lat", n, 2);

    // Write while busy is ignored; reset mid-operation restores the table
    wr_cdf(5, 'h1234);
    chk("busy_wr_ignored", dut.cdf_r[5], 16'hA300);
`ifdef ARITH_DEC_ERR_EN
    chk("err_busy_wr", err, 1'b1);
`endif
    do_reset(1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_sym_valid", sym_valid, 1'b0);
    chk("midrst_cdf1", dut.cdf_r[1], 16'h1000);
    chk("midrst_cdf5", dut.cdf_r[5], 16'h5000);
`ifdef ARITH_DEC_ERR_EN
    chk("err_cleared", err, 1'b0);
`endif

    // Round trip through a reference encoder
    begin
      int          cdfm[SYMS+1];
      int          syms[NSYM];
      bit          q[$];
      logic [15:0] lo, hi, lo0;
      longint      rng;
      int          pend, got, errs, cyc;
      logic        rdy, sv, b;
      logic [SW-1:0] so;

      cdfm[0] = 0;
      cdfm[SYMS] = 65536;
      for (int i = 1; i < SYMS; i++) cdfm[i] = i * 4096 - 'h600 + int'($urandom_range(0, 'hC00));
      lo = 16'h0000; hi = 16'hFFFF; pend = 0;
      for (int k = 0; k < NSYM; k++) begin
        syms[k] = int'($urandom_range(0, SYMS - 1));
        rng = longint'(hi) - longint'(lo) + 1;
        lo0 = lo;
        hi  = 16'(longint'(lo0) + ((rng * cdfm[syms[k] + 1]) >> 16) - 1);
        lo  = 16'(longint'(lo0) + ((rng * cdfm[syms[k]]) >> 16));
        forever begin
          if (lo[15] == hi[15]) begin
            b = hi[15];
            q.push_back(b);
            repeat (pend) q.push_back(!b);
            pend = 0;
            lo = {lo[14:0], 1'b0};
            hi = {hi[14:0], 1'b1};
          end else if (lo[15:14] == 2'b01 && hi[15:14] == 2'b10) begin
            pend++;
            lo = {lo[14:0], 1'b0} ^ 16'h8000;
            hi = {hi[14:0], 1'b1} ^ 16'h8000;
          end else break;
        end
      end
      pend++;
      b = (lo >= 16'h4000);
      q.push_back(b);
      repeat (pend) q.push_back(!b);

      do_reset(1);
      for (int i = 1; i < SYMS; i++) wr_cdf(i, cdfm[i]);
      start = 1'b1;
      tick();
      start = 1'b0;
      sym_ready = 1'b1;
      got = 0; errs = 0; cyc = 0;
      while (got < NSYM && cyc < 60000) begin
        bit_valid = 1'b1;
        bit_in = (q.size() > 0) ? q[0] : 1'b0;
        rdy = bit_ready; sv = sym_valid; so = sym_out;
        tick();
        cyc++;
        if (rdy && q.size() > 0) void'(q.pop_front());
        if (sv) begin
          if (int'(so) != syms[got]) errs++;
          got++;
        end
      end
      bit_valid = 1'b0;
      sym_ready = 1'b0;
      chk("rt_symbol_count", got, NSYM);
      chk("rt_symbol_errors", errs, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
